// File: rtl/seq_alu_if.sv
// Operand, opcode and status bundle between a sequencer (master) and seq_alu (slave).
// The accumulator value and all status flags are driven from registers inside seq_alu.
interface seq_alu_if #(
   parameter int W = 16
) ();
   logic         start;
   logic [3:0]   opcode;
   logic         use_acc;
   logic [W-1:0] input1;
   logic [W-1:0] input2;
   logic [W-1:0] out;
   logic         busy;
   logic         done;
   logic         zero;
   logic         carry;
   logic         ovf;
   logic         divz;

   modport master (
      output start, opcode, use_acc, input1, input2,
      input  out, busy, done, zero, carry, ovf, divz
   );

   modport slave (
      input  start, opcode, use_acc, input1, input2,
      output out, busy, done, zero, carry, ovf, divz
   );
endinterface

// File: rtl/seq_alu.sv
// Handshaked accumulator ALU: single-cycle logic/add/sub/shift ops plus
// bit-serial multiply and restoring divide/modulo, all writing one accumulator.
module seq_alu #(
   parameter int W = 16
) (
   input logic     clk,
   input logic     clear,
   seq_alu_if.slave bus
);
   localparam int CW = $clog2(W);

   localparam logic [3:0] OP_NOOP  = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_MULT  = 4'b0011;
   localparam logic [3:0] OP_DIV   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_XOR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1000;
   localparam logic [3:0] OP_SHL   = 4'b1001;
   localparam logic [3:0] OP_SHR   = 4'b1010;
   localparam logic [3:0] OP_MOD   = 4'b1011;
   localparam logic [3:0] OP_RESET = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   state_t          state_r, state_n;
   logic [CW-1:0]   cnt_r, cnt_n;
   logic [W-1:0]    a_r, a_n;
   logic [W-1:0]    b_r, b_n;
   logic            is_mod_r, is_mod_n;
   logic [2*W-1:0]  prod_r, prod_n;
   logic [W-1:0]    rem_r, rem_n;
   logic [W-1:0]    quo_r, quo_n;
   logic [W-1:0]    acc_r, acc_n;
   logic            zero_r, zero_n;
   logic            carry_r, carry_n;
   logic            ovf_r, ovf_n;
   logic            divz_r, divz_n;
   logic            done_r, done_n;
   logic            busy_r, busy_n;

   logic [W-1:0]    op_a_s;
   logic [W:0]      add_s;
   logic [W-1:0]    sub_s;
   logic [W:0]      mul_sum_s;
   logic [2*W-1:0]  prod_step_s;
   logic [W:0]      div_shift_s;
   logic [W:0]      div_diff_s;
   logic            div_ge_s;
   logic [W-1:0]    rem_step_s;
   logic [W-1:0]    quo_step_s;

   // Result-writeback staging shared by the single-cycle and iterative paths.
   logic            wr_s;
   logic [W-1:0]    res_s;
   logic            res_c_s;
   logic            res_v_s;
   logic            res_dz_s;

   assign op_a_s      = bus.use_acc ? acc_r : bus.input1;
   assign add_s       = {1'b0, op_a_s} + {1'b0, bus.input2};
   assign sub_s       = op_a_s - bus.input2;

   // One shift-add step: conditionally add A to the upper half, then shift the product right.
   assign mul_sum_s   = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, a_r} : {(W+1){1'b0}});
   assign prod_step_s = {mul_sum_s, prod_r[W-1:1]};

   // One restoring-division step: bring in the next dividend bit, subtract if it fits.
   assign div_shift_s = {rem_r, quo_r[W-1]};
   assign div_diff_s  = div_shift_s - {1'b0, b_r};
   assign div_ge_s    = (div_shift_s >= {1'b0, b_r});
   assign rem_step_s  = div_ge_s ? div_diff_s[W-1:0] : div_shift_s[W-1:0];
   assign quo_step_s  = {quo_r[W-2:0], div_ge_s};

   // Next-state, datapath and result computation for the IDLE/MUL/DIV controller.
   always_comb begin
      state_n  = state_r;
      cnt_n    = cnt_r;
      a_n      = a_r;
      b_n      = b_r;
      is_mod_n = is_mod_r;
      prod_n   = prod_r;
      rem_n    = rem_r;
      quo_n    = quo_r;
      acc_n    = acc_r;
      zero_n   = zero_r;
      carry_n  = carry_r;
      ovf_n    = ovf_r;
      divz_n   = divz_r;
      done_n   = 1'b0;
      wr_s     = 1'b0;
      res_s    = {W{1'b0}};
      res_c_s  = 1'b0;
      res_v_s  = 1'b0;
      res_dz_s = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               done_n = 1'b1;
               case (bus.opcode)
                  OP_ADD: begin
                     wr_s    = 1'b1;
                     res_s   = add_s[W-1:0];
                     res_c_s = add_s[W];
                     res_v_s = (op_a_s[W-1] == bus.input2[W-1]) && (add_s[W-1] != op_a_s[W-1]);
                  end
                  OP_SUB: begin
                     wr_s    = 1'b1;
                     res_s   = sub_s;
                     res_c_s = (op_a_s < bus.input2);
                     res_v_s = (op_a_s[W-1] != bus.input2[W-1]) && (sub_s[W-1] != op_a_s[W-1]);
                  end
                  OP_MULT: begin
                     done_n  = 1'b0;
                     a_n     = op_a_s;
                     prod_n  = {{W{1'b0}}, bus.input2};
                     cnt_n   = {CW{1'b0}};
                     state_n = ST_MUL;
                  end
                  OP_DIV, OP_MOD: begin
                     if (bus.input2 == {W{1'b0}}) begin
                        wr_s     = 1'b1;
                        res_s    = (bus.opcode == OP_MOD) ? op_a_s : {W{1'b1}};
                        res_dz_s = 1'b1;
                     end else begin
                        done_n   = 1'b0;
                        quo_n    = op_a_s;
                        rem_n    = {W{1'b0}};
                        b_n      = bus.input2;
                        is_mod_n = (bus.opcode == OP_MOD);
                        cnt_n    = {CW{1'b0}};
                        state_n  = ST_DIV;
                     end
                  end
                  OP_AND: begin
                     wr_s  = 1'b1;
                     res_s = op_a_s & bus.input2;
                  end
                  OP_OR: begin
                     wr_s  = 1'b1;
                     res_s = op_a_s | bus.input2;
                  end
                  OP_XOR: begin
                     wr_s  = 1'b1;
                     res_s = op_a_s ^ bus.input2;
                  end
                  OP_NOT: begin
                     wr_s  = 1'b1;
                     res_s = ~op_a_s;
                  end
                  OP_SHL: begin
                     wr_s    = 1'b1;
                     res_s   = {op_a_s[W-2:0], 1'b0};
                     res_c_s = op_a_s[W-1];
                  end
                  OP_SHR: begin
                     wr_s    = 1'b1;
                     res_s   = {1'b0, op_a_s[W-1:1]};
                     res_c_s = op_a_s[0];
                  end
                  OP_RESET: begin
                     acc_n   = {W{1'b0}};
                     zero_n  = 1'b0;
                     carry_n = 1'b0;
                     ovf_n   = 1'b0;
                     divz_n  = 1'b0;
                  end
                  default: begin
                     acc_n = acc_r;
                  end
               endcase
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_MUL: begin
            prod_n = prod_step_s;
            if (cnt_r == CW'(W - 1)) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
               wr_s    = 1'b1;
               res_s   = prod_step_s[W-1:0];
               res_v_s = |prod_step_s[2*W-1:W];
            end else begin
               cnt_n = cnt_r + CW'(1);
            end
         end
         ST_DIV: begin
            rem_n = rem_step_s;
            quo_n = quo_step_s;
            if (cnt_r == CW'(W - 1)) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
               wr_s    = 1'b1;
               res_s   = is_mod_r ? rem_step_s : quo_step_s;
            end else begin
               cnt_n = cnt_r + CW'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      if (wr_s) begin
         acc_n   = res_s;
         zero_n  = (res_s == {W{1'b0}});
         carry_n = res_c_s;
         ovf_n   = res_v_s;
         divz_n  = res_dz_s;
      end else begin
         acc_n = acc_n;
      end

      busy_n = (state_n != ST_IDLE);
   end

   // Controller, datapath and result registers; clear wins over any operation in flight.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CW{1'b0}};
         a_r      <= {W{1'b0}};
         b_r      <= {W{1'b0}};
         is_mod_r <= 1'b0;
         prod_r   <= {(2*W){1'b0}};
         rem_r    <= {W{1'b0}};
         quo_r    <= {W{1'b0}};
         acc_r    <= {W{1'b0}};
         zero_r   <= 1'b0;
         carry_r  <= 1'b0;
         ovf_r    <= 1'b0;
         divz_r   <= 1'b0;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_n;
         cnt_r    <= cnt_n;
         a_r      <= a_n;
         b_r      <= b_n;
         is_mod_r <= is_mod_n;
         prod_r   <= prod_n;
         rem_r    <= rem_n;
         quo_r    <= quo_n;
         acc_r    <= acc_n;
         zero_r   <= zero_n;
         carry_r  <= carry_n;
         ovf_r    <= ovf_n;
         divz_r   <= divz_n;
         done_r   <= done_n;
         busy_r   <= busy_n;
      end
   end

   assign bus.out   = acc_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.zero  = zero_r;
   assign bus.carry = carry_r;
   assign bus.ovf   = ovf_r;
   assign bus.divz  = divz_r;
endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu against an arithmetic reference model
// that works from operation semantics, latency and flag rules.
module tb_seq_alu;
   localparam int W = 16;

   localparam logic [3:0] T_NOOP = 4'd0,  T_ADD = 4'd1,  T_SUB = 4'd2,  T_MULT = 4'd3;
   localparam logic [3:0] T_DIV  = 4'd4,  T_AND = 4'd5,  T_OR  = 4'd6,  T_XOR  = 4'd7;
   localparam logic [3:0] T_NOT  = 4'd8,  T_SHL = 4'd9,  T_SHR = 4'd10, T_MOD  = 4'd11;
   localparam logic [3:0] T_RST  = 4'd15;

   logic clk;
   logic clear;
   int   checks;
   int   errors;

   logic [W-1:0] m_acc;
   logic         m_zero, m_carry, m_ovf, m_divz;

   seq_alu_if #(.W(W)) bus ();

   seq_alu #(.W(W)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = '0; m_zero = 1'b0; m_carry = 1'b0; m_ovf = 1'b0; m_divz = 1'b0;
   endtask

   // Reference: apply one operation's effect using ordinary integer arithmetic.
   task automatic model_apply(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned ua, ub, r;
      int sa, sb, s;
      bit wr, c, v, dz;
      ua = a; ub = b; sa = int'($signed(a)); sb = int'($signed(b));
      wr = 1'b1; c = 1'b0; v = 1'b0; dz = 1'b0; r = 0;
      case (op)
         T_ADD:  begin r = (ua + ub) % 65536; c = (ua + ub) > 65535; s = sa + sb; v = (s > 32767) || (s < -32768); end
         T_SUB:  begin r = (ua + 65536 - ub) % 65536; c = ua < ub; s = sa - sb; v = (s > 32767) || (s < -32768); end
         T_MULT: begin r = (ua * ub) % 65536; v = (ua * ub) > 65535; end
         T_DIV:  begin if (ub == 0) begin r = 65535; dz = 1'b1; end else r = ua / ub; end
         T_MOD:  begin if (ub == 0) begin r = ua; dz = 1'b1; end else r = ua % ub; end
         T_AND:  r = ua & ub;
         T_OR:   r = ua | ub;
         T_XOR:  r = ua ^ ub;
         T_NOT:  r = 65535 - ua;
         T_SHL:  begin r = (ua * 2) % 65536; c = ua >= 32768; end
         T_SHR:  begin r = ua / 2; c = ua % 2; end
         T_RST:  begin wr = 1'b0; model_reset(); end
         default: wr = 1'b0;
      endcase
      if (wr) begin
         m_acc = r[W-1:0]; m_zero = (r == 0); m_carry = c; m_ovf = v; m_divz = dz;
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".out"},   bus.out,   m_acc);
      chk({tag, ".zero"},  bus.zero,  m_zero);
      chk({tag, ".carry"}, bus.carry, m_carry);
      chk({tag, ".ovf"},   bus.ovf,   m_ovf);
      chk({tag, ".divz"},  bus.divz,  m_divz);
   endtask

   // Issue one op at the current negedge; returns at the negedge where done is seen.
   task automatic do_op(input string tag, input logic [3:0] op, input logic ua,
                        input logic [W-1:0] in1, input logic [W-1:0] in2, input bit poke);
      logic [W-1:0] a;
      bit multi;
      int k;
      a = ua ? m_acc : in1;
      multi = (op == T_MULT) || (((op == T_DIV) || (op == T_MOD)) && (in2 != '0));
      bus.start = 1'b1; bus.opcode = op; bus.use_acc = ua; bus.input1 = in1; bus.input2 = in2;
      @(negedge clk);
      bus.start = 1'b0; bus.opcode = 4'($urandom); bus.use_acc = 1'($urandom);
      bus.input1 = W'($urandom); bus.input2 = W'($urandom);
      model_apply(op, a, in2);
      if (multi) begin
         chk({tag, ".busy_on"}, bus.busy, 1'b1);
         chk({tag, ".no_early_done"}, bus.done, 1'b0);
         k = 0;
         while (bus.done !== 1'b1 && k < W + 4) begin
            if (poke && k == 3) begin
               bus.start = 1'b1; bus.opcode = T_RST; bus.use_acc = 1'b0;
            end
            @(negedge clk);
            k++;
            bus.start = 1'b0;
         end
         chk({tag, ".latency"}, k, W);
         chk({tag, ".busy_off"}, bus.busy, 1'b0);
      end else begin
         chk({tag, ".done"}, bus.done, 1'b1);
         chk({tag, ".busy_low"}, bus.busy, 1'b0);
      end
      check_state(tag);
   endtask

   task automatic idle_cycle(input string tag);
      @(negedge clk);
      chk({tag, ".done_drop"}, bus.done, 1'b0);
      chk({tag, ".idle"}, bus.busy, 1'b0);
   endtask

   initial begin
      logic [3:0] rop;
      logic [W-1:0] r1, r2;
      bit seen;
      checks = 0; errors = 0;
      bus.start = 1'b0; bus.opcode = '0; bus.use_acc = 1'b0; bus.input1 = '0; bus.input2 = '0;
      clear = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      clear = 1'b0;
      check_state("reset");
      chk("reset.busy", bus.busy, 1'b0);
      chk("reset.done", bus.done, 1'b0);

      do_op("add_wrap", T_ADD, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      chk("add_wrap.const", {bus.out, bus.zero, bus.carry}, {16'h0000, 1'b1, 1'b1});
      idle_cycle("add_wrap");
      do_op("add_ovf", T_ADD, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
      chk("add_ovf.const", {bus.out, bus.ovf}, {16'h8000, 1'b1});
      do_op("sub_borrow", T_SUB, 1'b0, 16'h0003, 16'h0005, 1'b0);
      chk("sub_borrow.const", {bus.out, bus.carry}, {16'hFFFE, 1'b1});
      do_op("mul_8x8", T_MULT, 1'b0, 16'h0008, 16'h0008, 1'b1);
      chk("mul_8x8.const", bus.out, 16'h0040);
      idle_cycle("mul_8x8");
      do_op("mul_ovf", T_MULT, 1'b0, 16'h0100, 16'h0100, 1'b0);
      chk("mul_ovf.const", {bus.out, bus.ovf, bus.zero}, {16'h0000, 1'b1, 1'b1});
      do_op("div_100_7", T_DIV, 1'b0, 16'd100, 16'd7, 1'b0);
      chk("div_100_7.const", bus.out, 16'd14);
      do_op("mod_100_7", T_MOD, 1'b0, 16'd100, 16'd7, 1'b0);
      chk("mod_100_7.const", bus.out, 16'd2);
      do_op("div_zero", T_DIV, 1'b0, 16'h1234, 16'h0000, 1'b0);
      chk("div_zero.const", {bus.out, bus.divz}, {16'hFFFF, 1'b1});
      do_op("mod_zero", T_MOD, 1'b0, 16'h1234, 16'h0000, 1'b0);
      idle_cycle("mod_zero");

      do_op("chain_add", T_ADD, 1'b0, 16'd5, 16'd3, 1'b0);
      do_op("chain_acc", T_ADD, 1'b1, 16'hAAAA, 16'd2, 1'b0);
      do_op("chain_shl", T_SHL, 1'b1, 16'h5555, 16'd0, 1'b0);
      chk("chain_shl.const", bus.out, 16'd20);

      for (int i = 0; i < 150; i++) begin
         rop = 4'($urandom);
         r1  = W'($urandom);
         r2  = ($urandom_range(0, 7) == 0) ? '0 : (($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 40)) : W'($urandom));
         do_op("rand", rop, 1'($urandom), r1, r2, 1'($urandom));
         if ($urandom_range(0, 1) == 1) idle_cycle("rand");
      end

      // Clear held two cycles while a multiply is in flight and start is requested.
      bus.start = 1'b1; bus.opcode = T_MULT; bus.use_acc = 1'b0;
      bus.input1 = W'($urandom); bus.input2 = W'($urandom) | 16'h0001;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      clear = 1'b1; bus.start = 1'b1; bus.opcode = T_ADD;
      repeat (2) @(negedge clk);
      clear = 1'b0; bus.start = 1'b0;
      model_reset();
      check_state("clear_mid");
      chk("clear_mid.busy", bus.busy, 1'b0);
      chk("clear_mid.done", bus.done, 1'b0);
      idle_cycle("clear_mid");

      // Abort a divide at its fifth iteration.
      do_op("pre_abort", T_ADD, 1'b0, 16'h0101, 16'h0202, 1'b0);
      bus.start = 1'b1; bus.opcode = T_DIV; bus.use_acc = 1'b0;
      bus.input1 = 16'hFFFF; bus.input2 = 16'h0003;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      check_state("abort");
      chk("abort.busy", bus.busy, 1'b0);
      chk("abort.done", bus.done, 1'b0);
      seen = 1'b0;
      repeat (W + 4) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      chk("abort.no_done", seen, 1'b0);

      do_op("carry_then_rst", T_ADD, 1'b0, 16'hFFFF, 16'h0002, 1'b0);
      chk("carry_then_rst.carry", bus.carry, 1'b1);
      do_op("rst_op", T_RST, 1'b0, 16'h1111, 16'h2222, 1'b0);
      chk("rst_op.const", {bus.out, bus.zero, bus.carry, bus.ovf, bus.divz}, {16'h0000, 4'b0000});
      do_op("noop", T_NOOP, 1'b0, 16'h3333, 16'h4444, 1'b0);
      idle_cycle("tail");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
